// File: rtl/serial_seq_pkg.sv
// Shared types and helpers for the serial_seq_gen serial pattern transmitter.
package serial_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Zero or oversized lengths both mean "the whole register".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    int unsigned r;
    if ((len == 32'd0) || (len > width)) begin
      r = width;
    end else begin
      r = len;
    end
    return r;
  endfunction

  function automatic int unsigned eff_reps(input int unsigned reps);
    int unsigned r;
    if (reps == 32'd0) begin
      r = 32'd1;
    end else begin
      r = reps;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable MSB-first shift register: holds a latched pattern and length, presents
// the selected bit on a registered serial output together with its bit index.
module serial_shift_reg #(
  parameter int   WIDTH    = 8,
  parameter int   LEN_W    = 4,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             cp,
  input  logic             clrn,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             sout,
  output logic [LEN_W-1:0] idx
);

  logic [WIDTH-1:0] data_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] idx_r;
  logic             sout_r;
  logic [WIDTH-1:0] src_s;
  logic [LEN_W-1:0] nidx_s;
  logic             bit_s;

  // Select the next index and the bit it points at.
  always_comb begin
    src_s  = data_r;
    nidx_s = idx_r;
    if (load) begin
      src_s  = load_data;
      nidx_s = load_len - LEN_W'(1);
    end else if (reload) begin
      nidx_s = len_r - LEN_W'(1);
    end else if (shift) begin
      nidx_s = idx_r - LEN_W'(1);
    end else begin
      nidx_s = idx_r;
    end
    bit_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (nidx_s == LEN_W'(i)) begin
        bit_s = src_s[i];
      end else begin
        bit_s = bit_s;
      end
    end
  end

  // Pattern, length, index and serial output registers.
  always_ff @(posedge cp or negedge clrn) begin
    if (!clrn) begin
      data_r <= {WIDTH{1'b0}};
      len_r  <= {LEN_W{1'b0}};
      idx_r  <= {LEN_W{1'b0}};
      sout_r <= IDLE_LVL;
    end else if (load) begin
      data_r <= load_data;
      len_r  <= load_len;
      idx_r  <= nidx_s;
      sout_r <= bit_s;
    end else if (reload || shift) begin
      idx_r  <= nidx_s;
      sout_r <= bit_s;
    end else if (clear) begin
      idx_r  <= {LEN_W{1'b0}};
      sout_r <= IDLE_LVL;
    end else begin
      idx_r  <= idx_r;
      sout_r <= sout_r;
    end
  end

  assign sout = sout_r;
  assign idx  = idx_r;

endmodule

// File: rtl/serial_seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first on X, R times back to back.
// Optional SERIAL_SEQ_GEN_ABORT_EN adds an abort input and an aborted status output.
module serial_seq_gen
  import serial_seq_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = 1'b0,
  localparam int  LEN_W    = $clog2(WIDTH + 1)
) (
  input  logic             CP,
  input  logic             CLRn,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
`ifdef SERIAL_SEQ_GEN_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             X,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] rep_r;
  logic             busy_r;
  logic             done_r;
  logic             load_s;
  logic             reload_s;
  logic             shift_s;
  logic             clear_s;
  logic             abort_s;
  logic             last_bit_s;
  logic [LEN_W-1:0] idx_s;
  logic [LEN_W-1:0] len_eff_s;
  logic [CNT_W-1:0] reps_m1_s;

`ifdef SERIAL_SEQ_GEN_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign len_eff_s  = LEN_W'(eff_len(32'(len), WIDTH));
  assign reps_m1_s  = CNT_W'(eff_reps(32'(reps)) - 32'd1);
  assign last_bit_s = (idx_s == {LEN_W{1'b0}}) && (rep_r == {CNT_W{1'b0}});

  // State, repetition counter and registered status flags.
  always_ff @(posedge CP or negedge CLRn) begin
    if (!CLRn) begin
      state_r <= ST_IDLE;
      rep_r   <= {CNT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_SEND);
      done_r  <= (next_state_s == ST_DONE);
      if (load_s) begin
        rep_r <= reps_m1_s;
      end else if (reload_s) begin
        rep_r <= rep_r - CNT_W'(1);
      end else begin
        rep_r <= rep_r;
      end
    end
  end

  // Next state. The edge leaving DONE doubles as the idle sampling point, so a
  // held start leaves exactly one idle-level bit between streams.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_SEND;
        else       next_state_s = ST_IDLE;
      end
      ST_SEND: begin
        if (abort_s || last_bit_s) next_state_s = ST_DONE;
        else                       next_state_s = ST_SEND;
      end
      ST_DONE: begin
        if (start) next_state_s = ST_SEND;
        else       next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Shift-register control strobes.
  always_comb begin
    load_s   = 1'b0;
    reload_s = 1'b0;
    shift_s  = 1'b0;
    clear_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        load_s = start;
      end
      ST_SEND: begin
        if (abort_s || last_bit_s) begin
          clear_s = 1'b1;
        end else if (idx_s == {LEN_W{1'b0}}) begin
          reload_s = 1'b1;
        end else begin
          shift_s = 1'b1;
        end
      end
      default: begin
        clear_s = 1'b1;
      end
    endcase
  end

`ifdef SERIAL_SEQ_GEN_ABORT_EN
  logic aborted_r;

  // Flags a DONE entered before the final bit had been sent.
  always_ff @(posedge CP or negedge CLRn) begin
    if (!CLRn) begin
      aborted_r <= 1'b0;
    end else begin
      aborted_r <= (state_r == ST_SEND) && abort && !last_bit_s;
    end
  end

  assign aborted = aborted_r;
`endif

  serial_shift_reg #(
    .WIDTH   (WIDTH),
    .LEN_W   (LEN_W),
    .IDLE_LVL(IDLE_LVL)
  ) u_shift (
    .cp       (CP),
    .clrn     (CLRn),
    .load     (load_s),
    .reload   (reload_s),
    .shift    (shift_s),
    .clear    (clear_s),
    .load_data(pattern),
    .load_len (len_eff_s),
    .sout     (X),
    .idx      (idx_s)
  );

  assign busy    = busy_r;
  assign done    = done_r;
  assign bit_idx = idx_s;

endmodule

// File: tb/tb_serial_seq_gen.sv
// Self-checking bench for serial_seq_gen: directed cases plus random transmissions
// compared against a per-cycle stream model built from the pattern/len/reps rules.
module tb_serial_seq_gen;

  localparam int W = 8;

  logic       CP;
  logic       CLRn;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       X;
  logic       busy;
  logic       done;
  logic [3:0] bit_idx;
`ifdef SERIAL_SEQ_GEN_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic x;
    logic busy;
    logic done;
    int   idx;
  } exp_t;

  exp_t q[$];

  serial_seq_gen #(.WIDTH(8), .CNT_W(4), .IDLE_LVL(1'b0)) dut (
    .CP(CP), .CLRn(CLRn), .start(start), .pattern(pattern), .len(len), .reps(reps),
`ifdef SERIAL_SEQ_GEN_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .X(X), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, {31'd0, X}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_idx"}, {28'd0, bit_idx}, 32'd0);
  endtask

  // Append one complete stream: R passes of L bits MSB-first, then the done cycle.
  task automatic build(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp);
    int l;
    int r;
    l = (ln == 4'd0 || int'(ln) > W) ? W : int'(ln);
    r = (rp == 4'd0) ? 1 : int'(rp);
    for (int p = 0; p < r; p++)
      for (int i = l - 1; i >= 0; i--)
        q.push_back('{x: pat[i], busy: 1'b1, done: 1'b0, idx: i});
    q.push_back('{x: 1'b0, busy: 1'b0, done: 1'b1, idx: 0});
  endtask

  task automatic send(input logic [7:0] pat, input logic [3:0] ln, input logic [3:0] rp,
                      input int copies, input int repulse_at, input int rst_at,
                      input int abort_at);
    bit hold;
    hold = (copies > 1);
    q.delete();
    for (int c = 0; c < copies; c++) build(pat, ln, rp);
    @(negedge CP);
    pattern = pat; len = ln; reps = rp; start = 1'b1;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge CP);
      chk("x", {31'd0, X}, {31'd0, q[k].x});
      chk("busy", {31'd0, busy}, {31'd0, q[k].busy});
      chk("done", {31'd0, done}, {31'd0, q[k].done});
      chk("bit_idx", {28'd0, bit_idx}, 32'(q[k].idx));
`ifdef SERIAL_SEQ_GEN_ABORT_EN
      chk("aborted_low", {31'd0, aborted}, 32'd0);
`endif
      start = hold && (k < q.size() - 1);
      if (k == 0 && !hold) begin
        pattern = 8'($urandom); len = 4'($urandom); reps = 4'($urandom);
      end
      if (k == repulse_at) begin
        start = 1'b1;
        pattern = ~pat;
      end
      if (k == rst_at) begin
        #2 CLRn = 1'b0;
        #1 chk_idle("rst_async");
        start = 1'b0;
        return;
      end
`ifdef SERIAL_SEQ_GEN_ABORT_EN
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge CP);
        abort = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_flag", {31'd0, aborted}, 32'd1);
        chk("abort_x", {31'd0, X}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        break;
      end
`endif
    end
    @(negedge CP);
    chk_idle("post_idle");
  endtask

  initial begin
    CLRn = 1'b0; start = 1'b0; pattern = 8'd0; len = 4'd0; reps = 4'd0;
`ifdef SERIAL_SEQ_GEN_ABORT_EN
    abort = 1'b0;
`endif
    #1 chk_idle("reset");
    @(negedge CP);
    CLRn = 1'b1;

    // Full-width single pass, then three passes of a 3-bit pattern.
    send(8'b10110010, 4'd0, 4'd1, 1, -1, -1, -1);
    send(8'b00000101, 4'd3, 4'd3, 1, -1, -1, -1);
    // Restart request mid-stream must be ignored.
    send(8'b10110010, 4'd0, 4'd1, 1, 3, -1, -1);
    // Oversized length clamps to the full width; reps=0 means one pass.
    send(8'b01101001, 4'd12, 4'd0, 1, -1, -1, -1);
    // Held start: back-to-back streams separated by one idle bit.
    send(8'b00000011, 4'd2, 4'd1, 3, -1, -1, -1);

    // Asynchronous reset during bit 4; no done afterwards, then a clean restart.
    send(8'b10110010, 4'd0, 4'd1, 1, -1, 4, -1);
    @(negedge CP);
    chk_idle("rst_held");
    CLRn = 1'b1;
    @(negedge CP);
    chk_idle("rst_release");
    send(8'b11100100, 4'd0, 4'd1, 1, -1, -1, -1);

`ifdef SERIAL_SEQ_GEN_ABORT_EN
    send(8'b10110010, 4'd0, 4'd1, 1, -1, -1, 4);
    send(8'b10110010, 4'd0, 4'd1, 1, -1, -1, -1);
`endif

    for (int n = 0; n < 16; n++)
      send(8'($urandom), 4'($urandom), 4'($urandom_range(0, 5)), 1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
